// File: rtl/seg_scan_decoder.sv
// Receive side of the parking display scan bus: rebuilds left/right digit codes from the
// multiplexed SEG_SEL/SEG_DATA stream and publishes them once the scan is stable.
module seg_scan_decoder #(
    parameter int unsigned STABLE_FRAMES  = 2,
    parameter int unsigned TIMEOUT_CYCLES = 8,
    parameter logic [4:0]  SEL_LEFT       = 5'b00100,
    parameter logic [4:0]  SEL_RIGHT      = 5'b00010
) (
    input  logic       clk_500Hz,
    input  logic       reset,
    input  logic [4:0] SEG_SEL,
    input  logic [7:0] SEG_DATA,
    input  logic       err_clr,
    output logic [3:0] left_code,
    output logic [3:0] right_code,
    output logic       left_dp,
    output logic       right_dp,
    output logic       frame_valid,
    output logic       locked,
    output logic       scan_err
);

    localparam int MW = $clog2(STABLE_FRAMES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [MW-1:0] MATCH_MAX = MW'(STABLE_FRAMES - 1);
    localparam logic [TW-1:0] TO_LIM    = TW'(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic {WAIT_L, WAIT_R} state_t;

    function automatic logic [3:0] seg_decode(input logic [6:0] seg);
        case (seg)
            7'h3F:   seg_decode = 4'h0;
            7'h06:   seg_decode = 4'h1;
            7'h5B:   seg_decode = 4'h2;
            7'h4F:   seg_decode = 4'h3;
            7'h66:   seg_decode = 4'h4;
            7'h6D:   seg_decode = 4'h5;
            7'h7D:   seg_decode = 4'h6;
            7'h07:   seg_decode = 4'h7;
            7'h7F:   seg_decode = 4'h8;
            7'h6F:   seg_decode = 4'h9;
            7'h40:   seg_decode = 4'hA;
            7'h00:   seg_decode = 4'hB;
            default: seg_decode = 4'hF;
        endcase
    endfunction

    state_t          r_state;
    state_t          w_state_nxt;
    logic [3:0]      r_lcode;
    logic            r_ldp;
    logic [9:0]      r_cand;
    logic [MW-1:0]   r_match;
    logic [TW-1:0]   r_to_cnt;

    logic [3:0]      w_code;
    logic            w_latch_l;
    logic            w_frame_done;
    logic            w_err_set;
    logic            w_timeout;
    logic [9:0]      w_frame;
    logic [MW-1:0]   w_match_nxt;
    logic            w_publish;

    assign w_code  = seg_decode(SEG_DATA[6:0]);
    assign w_frame = {r_lcode, r_ldp, w_code, SEG_DATA[7]};

    always_comb begin
        w_state_nxt  = r_state;
        w_latch_l    = 1'b0;
        w_frame_done = 1'b0;
        w_err_set    = 1'b0;
        w_timeout    = 1'b0;
        w_match_nxt  = '0;
        w_publish    = 1'b0;

        // A left sample while already waiting for the right digit is an order error.
        if (SEG_SEL == SEL_LEFT) begin
            w_latch_l   = 1'b1;
            w_state_nxt = WAIT_R;
            w_err_set   = (w_code == 4'hF) || (r_state == WAIT_R);
        end else if (SEG_SEL == SEL_RIGHT) begin
            if (r_state == WAIT_R) begin
                w_frame_done = 1'b1;
                w_state_nxt  = WAIT_L;
                w_err_set    = (w_code == 4'hF);
            end
        end else if (SEG_SEL != 5'd0) begin
            w_err_set = 1'b1;
        end

        // Timeout acts only on the cycle the counter reaches its limit, so a resumed scan can relock.
        w_timeout = !w_frame_done && (r_to_cnt == TO_LAST);
        if (w_timeout) begin
            w_state_nxt = WAIT_L;
        end

        if (w_frame == r_cand) begin
            w_match_nxt = (r_match == MATCH_MAX) ? r_match : r_match + MW'(1);
        end
        w_publish = w_frame_done && (w_match_nxt == MATCH_MAX) &&
                    ((w_frame != {left_code, left_dp, right_code, right_dp}) || !locked);
    end

    always_ff @(posedge clk_500Hz or negedge reset) begin
        if (!reset) begin
            r_state <= WAIT_L;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk_500Hz or negedge reset) begin
        if (!reset) begin
            r_lcode     <= '0;
            r_ldp       <= 1'b0;
            r_cand      <= '0;
            r_match     <= '0;
            r_to_cnt    <= '0;
            left_code   <= 4'hB;
            right_code  <= 4'hB;
            left_dp     <= 1'b0;
            right_dp    <= 1'b0;
            frame_valid <= 1'b0;
            locked      <= 1'b0;
            scan_err    <= 1'b0;
        end else begin
            frame_valid <= w_publish;
            if (w_latch_l) begin
                r_lcode <= w_code;
                r_ldp   <= SEG_DATA[7];
            end
            if (w_frame_done) begin
                r_cand   <= w_frame;
                r_match  <= w_match_nxt;
                r_to_cnt <= '0;
            end else begin
                if (r_to_cnt != TO_LIM) begin
                    r_to_cnt <= r_to_cnt + TW'(1);
                end
                if (w_timeout) begin
                    r_match <= '0;
                    locked  <= 1'b0;
                end
            end
            if (w_publish) begin
                {left_code, left_dp, right_code, right_dp} <= w_frame;
                locked <= 1'b1;
            end
            if (w_err_set) begin
                scan_err <= 1'b1;
            end else if (err_clr) begin
                scan_err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed bench for seg_scan_decoder: expected published frames are queued by the stimulus
// and checked by an independent monitor whenever frame_valid pulses.
module tb_seg_scan_decoder;

    localparam logic [4:0] SL = 5'b00100;
    localparam logic [4:0] SR = 5'b00010;

    logic       clk_500Hz = 1'b0;
    logic       reset;
    logic [4:0] SEG_SEL;
    logic [7:0] SEG_DATA;
    logic       err_clr;
    logic [3:0] left_code;
    logic [3:0] right_code;
    logic       left_dp;
    logic       right_dp;
    logic       frame_valid;
    logic       locked;
    logic       scan_err;

    int         n_cmp = 0;
    int         n_bad = 0;
    logic [9:0] exp_q[$];
    logic [9:0] mon_exp;

    always #5 clk_500Hz = ~clk_500Hz;

    seg_scan_decoder dut (
        .clk_500Hz  (clk_500Hz),
        .reset      (reset),
        .SEG_SEL    (SEG_SEL),
        .SEG_DATA   (SEG_DATA),
        .err_clr    (err_clr),
        .left_code  (left_code),
        .right_code (right_code),
        .left_dp    (left_dp),
        .right_dp   (right_dp),
        .frame_valid(frame_valid),
        .locked     (locked),
        .scan_err   (scan_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Monitor: every frame_valid pulse must match the oldest queued expectation.
    always @(negedge clk_500Hz) begin
        if (reset === 1'b1 && frame_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_frame_valid: got frame %0h, expected no pulse",
                         {left_code, left_dp, right_code, right_dp});
            end else begin
                mon_exp = exp_q.pop_front();
                check("published_frame", 32'({left_code, left_dp, right_code, right_dp}),
                      32'(mon_exp));
            end
        end
    end

    task automatic cyc(input logic [4:0] sel, input logic [7:0] data);
        SEG_SEL  = sel;
        SEG_DATA = data;
        @(posedge clk_500Hz);
        @(negedge clk_500Hz);
    endtask

    task automatic frame(input logic [7:0] l, input logic [7:0] r);
        cyc(SL, l);
        cyc(SR, r);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_left_code"}, 32'(left_code), 32'hB);
        check({tag, "_right_code"}, 32'(right_code), 32'hB);
        check({tag, "_dps"}, 32'({left_dp, right_dp}), 32'h0);
        check({tag, "_frame_valid"}, 32'(frame_valid), 32'h0);
        check({tag, "_locked"}, 32'(locked), 32'h0);
        check({tag, "_scan_err"}, 32'(scan_err), 32'h0);
    endtask

    initial begin
        reset    = 1'b0;
        SEG_SEL  = 5'd0;
        SEG_DATA = 8'h00;
        err_clr  = 1'b0;
        repeat (2) @(negedge clk_500Hz);
        check_reset_values("reset");
        reset = 1'b1;

        // 1: two identical frames publish left=4 dp=1, right=3 dp=0; a third is silent
        frame(8'hE6, 8'h4F);
        check("locked_after_one_frame", 32'(locked), 32'h0);
        exp_q.push_back({4'h4, 1'b1, 4'h3, 1'b0});
        frame(8'hE6, 8'h4F);
        check("t1_locked", 32'(locked), 32'h1);
        check("t1_left", 32'({left_code, left_dp}), 32'({4'h4, 1'b1}));
        check("t1_right", 32'({right_code, right_dp}), 32'({4'h3, 1'b0}));
        frame(8'hE6, 8'h4F);

        // 2: a single glitched frame is absorbed; two stable new frames publish
        frame(8'hE6, 8'h5B);
        frame(8'hE6, 8'h4F);
        frame(8'hE6, 8'h4F);
        check("t2_right_held", 32'(right_code), 32'h3);
        frame(8'hE6, 8'h5B);
        exp_q.push_back({4'h4, 1'b1, 4'h2, 1'b0});
        frame(8'hE6, 8'h5B);
        check("t2_right_new", 32'(right_code), 32'h2);

        // 3: dash and blank patterns
        frame(8'hE6, 8'h40);
        exp_q.push_back({4'h4, 1'b1, 4'hA, 1'b0});
        frame(8'hE6, 8'h40);
        check("t3_dash", 32'(right_code), 32'hA);
        frame(8'h00, 8'h40);
        exp_q.push_back({4'hB, 1'b0, 4'hA, 1'b0});
        frame(8'h00, 8'h40);
        check("t3_blank", 32'({left_code, left_dp}), 32'({4'hB, 1'b0}));

        // 4: eight idle cycles drop lock on the eighth edge, codes held, then relock
        repeat (7) cyc(5'd0, 8'h00);
        check("t4_locked_7_idle", 32'(locked), 32'h1);
        cyc(5'd0, 8'h00);
        check("t4_locked_8_idle", 32'(locked), 32'h0);
        check("t4_codes_held", 32'({left_code, right_code}), 32'hBA);
        exp_q.push_back({4'hB, 1'b0, 4'hA, 1'b0});
        frame(8'h00, 8'h40);
        check("t4_relocked", 32'(locked), 32'h1);
        frame(8'h00, 8'h40);

        // 5: invalid pattern, set-wins-over-clear, clear, order error with re-latch
        cyc(SL, 8'h12);
        check("t5_err_invalid", 32'(scan_err), 32'h1);
        cyc(SR, 8'h40);
        err_clr = 1'b1;
        cyc(5'b00001, 8'h00);
        err_clr = 1'b0;
        check("t5_set_wins", 32'(scan_err), 32'h1);
        err_clr = 1'b1;
        cyc(5'd0, 8'h00);
        err_clr = 1'b0;
        check("t5_cleared", 32'(scan_err), 32'h0);
        exp_q.push_back({4'hF, 1'b0, 4'hA, 1'b0});
        frame(8'h12, 8'h40);
        check("t5_left_invalid_code", 32'(left_code), 32'hF);
        check("t5_err_again", 32'(scan_err), 32'h1);
        err_clr = 1'b1;
        cyc(5'd0, 8'h00);
        err_clr = 1'b0;
        check("t5_cleared_again", 32'(scan_err), 32'h0);
        cyc(SL, 8'hE6);
        cyc(SL, 8'h06);
        check("t5_err_order", 32'(scan_err), 32'h1);
        cyc(SR, 8'h4F);
        err_clr = 1'b1;
        cyc(5'd0, 8'h00);
        err_clr = 1'b0;
        exp_q.push_back({4'h1, 1'b0, 4'h3, 1'b0});
        frame(8'h06, 8'h4F);
        check("t5_relatched_left", 32'({left_code, left_dp}), 32'({4'h1, 1'b0}));

        // 6: reset between left and right, lone right ignored, then normal publish
        cyc(SL, 8'h3F);
        reset = 1'b0;
        #1;
        check_reset_values("midreset");
        @(negedge clk_500Hz);
        reset = 1'b1;
        cyc(SR, 8'h06);
        check("t6_lone_right", 32'({right_code, locked}), 32'({4'hB, 1'b0}));
        frame(8'h3F, 8'h06);
        check("t6_not_yet", 32'(locked), 32'h0);
        exp_q.push_back({4'h0, 1'b0, 4'h1, 1'b0});
        frame(8'h3F, 8'h06);
        check("t6_locked", 32'(locked), 32'h1);
        check("t6_codes", 32'({left_code, right_code}), 32'h01);

        repeat (2) cyc(5'd0, 8'h00);
        check("pending_expected_frames", 32'(exp_q.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
